// File: rtl/jt49_pkg.sv
// Shared constants for the jt49 PSG: register indices, envelope shape fields,
// logarithmic volume table and the noise LFSR seed.
package jt49_pkg;

   localparam logic [3:0] REG_TONE_A_L  = 4'd0;
   localparam logic [3:0] REG_TONE_A_H  = 4'd1;
   localparam logic [3:0] REG_TONE_B_L  = 4'd2;
   localparam logic [3:0] REG_TONE_B_H  = 4'd3;
   localparam logic [3:0] REG_TONE_C_L  = 4'd4;
   localparam logic [3:0] REG_TONE_C_H  = 4'd5;
   localparam logic [3:0] REG_NOISE_PER = 4'd6;
   localparam logic [3:0] REG_MIXER     = 4'd7;
   localparam logic [3:0] REG_AMP_A     = 4'd8;
   localparam logic [3:0] REG_AMP_B     = 4'd9;
   localparam logic [3:0] REG_AMP_C     = 4'd10;
   localparam logic [3:0] REG_ENV_PER_L = 4'd11;
   localparam logic [3:0] REG_ENV_PER_H = 4'd12;
   localparam logic [3:0] REG_ENV_SHAPE = 4'd13;

   localparam logic [16:0] LFSR_SEED = 17'h00001;

   // 1.5 dB per step, top entry is full scale
   localparam logic [7:0] VOL_TABLE [32] = '{
      8'd0,   8'd1,   8'd2,   8'd2,   8'd2,   8'd3,   8'd3,   8'd4,
      8'd5,   8'd6,   8'd7,   8'd8,   8'd10,  8'd11,  8'd14,  8'd16,
      8'd19,  8'd23,  8'd27,  8'd32,  8'd38,  8'd45,  8'd54,  8'd64,
      8'd76,  8'd90,  8'd108, 8'd128, 8'd152, 8'd181, 8'd215, 8'd255
   };

   typedef struct packed {
      logic cont;
      logic att;
      logic alt;
      logic hold;
   } env_shape_t;

   function automatic logic [7:0] reg_mask(input logic [3:0] idx);
      logic [7:0] m;
      case (idx)
         REG_TONE_A_H, REG_TONE_B_H, REG_TONE_C_H, REG_ENV_SHAPE: m = 8'h0F;
         REG_NOISE_PER, REG_AMP_A, REG_AMP_B, REG_AMP_C:         m = 8'h1F;
         default:                                                m = 8'hFF;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/jt49_psg_tone.sv
// One square-tone channel: 12-bit period counter toggling a flip-flop.
module jt49_psg_tone
   import jt49_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        tick,
   input  logic [11:0] period,
   output logic        tone
);

   logic [11:0] cnt_r;
   logic [11:0] per_s;
   logic        wrap_s;

   // Period 0 counts as 1; ">=" also recovers when the period shrinks below the count
   always_comb begin
      per_s  = (period == 12'd0) ? 12'd1 : period;
      wrap_s = (({1'b0, cnt_r} + 13'd1) >= {1'b0, per_s});
   end

   // Counter and output flip-flop advance only on the timebase tick
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= 12'd0;
         tone  <= 1'b0;
      end else if (tick) begin
         if (wrap_s) begin
            cnt_r <= 12'd0;
            tone  <= ~tone;
         end else begin
            cnt_r <= cnt_r + 12'd1;
         end
      end
   end

endmodule

// File: rtl/jt49_psg.sv
// AY-3-8910/YM2149-compatible PSG: register file, timebase, noise, envelope
// and mixer; three tone channels come from jt49_psg_tone instances.
module jt49_psg
   import jt49_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cen,
   input  logic [3:0] addr,
   input  logic       cs_n,
   input  logic       wr_n,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   output logic [9:0] sound
);

   logic [15:0][7:0] regs_r;
   logic             wr_s;
   logic [3:0]       pre_r;
   logic             tick_s;
   logic             noise_half_r;
   logic [4:0]       noise_cnt_r;
   logic [4:0]       noise_per_s;
   logic             noise_wrap_s;
   logic [16:0]      lfsr_r;
   logic [15:0]      env_cnt_r;
   logic [15:0]      env_per_s;
   logic             env_wrap_s;
   logic [4:0]       env_step_r;
   logic             env_alt_r;
   logic             env_hold_r;
   logic [4:0]       env_s;
   env_shape_t       shape_s;
   logic [11:0]      period_s [3];
   logic [4:0]       amp_s [3];
   logic [2:0]       tone_s;
   logic [7:0]       chan_s [3];

   assign wr_s     = ~cs_n & ~wr_n;
   assign data_out = regs_r[addr];
   assign tick_s   = cen & (pre_r == 4'hF);

   always_comb begin
      shape_s      = env_shape_t'(regs_r[REG_ENV_SHAPE][3:0]);
      period_s[0]  = {regs_r[REG_TONE_A_H][3:0], regs_r[REG_TONE_A_L]};
      period_s[1]  = {regs_r[REG_TONE_B_H][3:0], regs_r[REG_TONE_B_L]};
      period_s[2]  = {regs_r[REG_TONE_C_H][3:0], regs_r[REG_TONE_C_L]};
      amp_s[0]     = regs_r[REG_AMP_A][4:0];
      amp_s[1]     = regs_r[REG_AMP_B][4:0];
      amp_s[2]     = regs_r[REG_AMP_C][4:0];
      noise_per_s  = (regs_r[REG_NOISE_PER][4:0] == 5'd0) ? 5'd1 : regs_r[REG_NOISE_PER][4:0];
      noise_wrap_s = (({1'b0, noise_cnt_r} + 6'd1) >= {1'b0, noise_per_s});
      env_per_s    = ({regs_r[REG_ENV_PER_H], regs_r[REG_ENV_PER_L]} == 16'd0) ? 16'd1 :
                     {regs_r[REG_ENV_PER_H], regs_r[REG_ENV_PER_L]};
      env_wrap_s   = (({1'b0, env_cnt_r} + 17'd1) >= {1'b0, env_per_s});
      env_s        = (shape_s.att ? env_step_r : (5'd31 - env_step_r)) ^ {5{env_alt_r}};
   end

   // Bus writes are independent of cen and store only implemented bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs_r <= '0;
      end else if (wr_s) begin
         regs_r[addr] <= data_in & reg_mask(addr);
      end
   end

   // Prescaler plus noise generator; noise counts every second tick
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_r        <= 4'd0;
         noise_half_r <= 1'b0;
         noise_cnt_r  <= 5'd0;
         lfsr_r       <= LFSR_SEED;
      end else begin
         if (cen) pre_r <= pre_r + 4'd1;
         if (tick_s) begin
            noise_half_r <= ~noise_half_r;
            if (noise_half_r) begin
               if (noise_wrap_s) begin
                  noise_cnt_r <= 5'd0;
                  lfsr_r      <= {lfsr_r[0] ^ lfsr_r[3], lfsr_r[16:1]};
               end else begin
                  noise_cnt_r <= noise_cnt_r + 5'd1;
               end
            end
         end
      end
   end

   // Envelope: a shape write restarts it even while cen is low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         env_cnt_r  <= 16'd0;
         env_step_r <= 5'd0;
         env_alt_r  <= 1'b0;
         env_hold_r <= 1'b0;
      end else if (wr_s && (addr == REG_ENV_SHAPE)) begin
         env_cnt_r  <= 16'd0;
         env_step_r <= 5'd0;
         env_alt_r  <= 1'b0;
         env_hold_r <= 1'b0;
      end else if (tick_s) begin
         if (!env_wrap_s) begin
            env_cnt_r <= env_cnt_r + 16'd1;
         end else begin
            env_cnt_r <= 16'd0;
            if (!env_hold_r) begin
               if (env_step_r != 5'd31) begin
                  env_step_r <= env_step_r + 5'd1;
               end else if (!shape_s.cont) begin
                  // alt = att turns the frozen step 31 into output 0
                  env_hold_r <= 1'b1;
                  env_alt_r  <= shape_s.att;
               end else if (shape_s.hold) begin
                  env_hold_r <= 1'b1;
                  env_alt_r  <= env_alt_r ^ shape_s.alt;
               end else begin
                  env_step_r <= 5'd0;
                  env_alt_r  <= env_alt_r ^ shape_s.alt;
               end
            end
         end
      end
   end

   for (genvar g = 0; g < 3; g++) begin : g_chan
      logic       gate_s;
      logic [4:0] idx_s;

      jt49_psg_tone u_tone (
         .clk    (clk),
         .rst_n  (rst_n),
         .tick   (tick_s),
         .period (period_s[g]),
         .tone   (tone_s[g])
      );

      assign gate_s    = (tone_s[g] | regs_r[REG_MIXER][g]) & (lfsr_r[0] | regs_r[REG_MIXER][g+3]);
      assign idx_s     = amp_s[g][4] ? env_s :
                         ((amp_s[g][3:0] == 4'd0) ? 5'd0 : {amp_s[g][3:0], 1'b1});
      assign chan_s[g] = gate_s ? VOL_TABLE[idx_s] : 8'd0;
   end

   // Registered mix of the three channels, one cen cycle of latency
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sound <= 10'd0;
      end else if (cen) begin
         sound <= {2'b00, chan_s[0]} + {2'b00, chan_s[1]} + {2'b00, chan_s[2]};
      end
   end

endmodule

// File: tb/tb_jt49_psg.sv
// Self-checking bench for jt49_psg: closed-form expectations from cen-edge
// counts, queued per cycle and compared after each clock edge.
module tb_jt49_psg;

   logic       clk = 1'b0;
   logic       rst_n, cen, cs_n, wr_n;
   logic [3:0] addr;
   logic [7:0] data_in, data_out;
   logic [9:0] sound;

   int vectors = 0;
   int errors  = 0;
   int n_cen;
   int exp_hold;
   logic [16:0] lfsr_m;
   int shifts_m;
   int exp_q[$];
   logic [7:0] rd_q[$];
   int vtab [32] = '{0, 1, 2, 2, 2, 3, 3, 4, 5, 6, 7, 8, 10, 11, 14, 16,
                     19, 23, 27, 32, 38, 45, 54, 64, 76, 90, 108, 128, 152, 181, 215, 255};

   always #5 clk = ~clk;

   jt49_psg dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cen      (cen),
      .addr     (addr),
      .cs_n     (cs_n),
      .wr_n     (wr_n),
      .data_in  (data_in),
      .data_out (data_out),
      .sound    (sound)
   );

   function automatic logic [7:0] bmask(input int a);
      case (a)
         1, 3, 5, 13:  return 8'h0F;
         6, 8, 9, 10:  return 8'h1F;
         default:      return 8'hFF;
      endcase
   endfunction

   function automatic int env_val(input logic [3:0] sh, input int s);
      int cyc, pos, base, last;
      cyc  = s / 32;
      pos  = s % 32;
      base = sh[2] ? pos : 31 - pos;
      last = sh[2] ? 31 : 0;
      if (cyc == 0) return base;
      if (!sh[3]) return 0;
      if (sh[0]) return sh[1] ? 31 - last : last;
      return (sh[1] && (cyc % 2 == 1)) ? 31 - base : base;
   endfunction

   function automatic int tone_bit(input int n, input int p);
      return ((n / 16) / p) % 2;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0; cen = 1'b0; cs_n = 1'b1; wr_n = 1'b1; addr = 4'd0; data_in = 8'd0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      n_cen = 0;
      exp_hold = 0;
   endtask

   task automatic wr(input int a, input int d);
      cen = 1'b0; cs_n = 1'b0; wr_n = 1'b0; addr = 4'(a); data_in = 8'(d);
      @(posedge clk);
      #1 cs_n = 1'b1; wr_n = 1'b1;
   endtask

   task automatic test_reset();
      int got;
      do_reset();
      for (int a = 0; a < 16; a++) wr(a, 8'hFF);
      do_reset();
      vectors++;
      if (sound !== 10'd0) begin
         errors++; $display("FAIL reset_sound got %0d want 0", sound);
      end
      for (int a = 0; a < 16; a++) begin
         addr = 4'(a);
         rd_q.push_back(8'h00);
         #1;
         got = int'(rd_q.pop_front());
         vectors++;
         if (data_out !== 8'(got)) begin
            errors++; $display("FAIL reset_reg%0d got %0h want %0h", a, data_out, got);
         end
      end
   endtask

   task automatic test_tone();
      int want;
      do_reset();
      wr(0, 8'h11); wr(1, 8'h01); wr(8, 8'h0F); wr(7, 8'h3E);
      while (n_cen < 14000) begin
         cen = ($urandom_range(0, 7) != 0);
         if (cen) exp_hold = 255 * tone_bit(n_cen, 273);
         exp_q.push_back(exp_hold);
         @(posedge clk);
         #1;
         want = exp_q.pop_front();
         vectors++;
         if (sound !== 10'(want)) begin
            errors++; $display("FAIL tone n=%0d got %0d want %0d", n_cen, sound, want);
         end
         if (cen) n_cen++;
      end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if (sound !== 10'd0) begin
         errors++; $display("FAIL async_reset got %0d want 0", sound);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_three_tones();
      int want;
      int peak = 0;
      do_reset();
      wr(0, 8'h11); wr(1, 8'h01); wr(2, 8'h22); wr(3, 8'h02); wr(4, 8'h23); wr(5, 8'h03);
      wr(8, 8'h0F); wr(9, 8'h0F); wr(10, 8'h0F); wr(7, 8'h38);
      cen = 1'b1;
      while (n_cen < 18000) begin
         exp_q.push_back(255 * (tone_bit(n_cen, 273) + tone_bit(n_cen, 546) + tone_bit(n_cen, 803)));
         @(posedge clk);
         #1;
         want = exp_q.pop_front();
         vectors++;
         if (sound !== 10'(want)) begin
            errors++; $display("FAIL three_tones n=%0d got %0d want %0d", n_cen, sound, want);
         end
         if (int'(sound) > peak) peak = int'(sound);
         n_cen++;
      end
      vectors++;
      if (peak != 765) begin
         errors++; $display("FAIL three_tones_peak got %0d want 765", peak);
      end
   endtask

   task automatic test_noise(input int per);
      int want, target;
      do_reset();
      lfsr_m = 17'h1;
      shifts_m = 0;
      wr(0, 0); wr(1, 0); wr(6, per); wr(8, 8'h0F); wr(7, 8'h31);
      cen = 1'b1;
      while (n_cen < 3200) begin
         target = ((n_cen / 16) / 2) / per;
         while (shifts_m < target) begin
            lfsr_m = {lfsr_m[0] ^ lfsr_m[3], lfsr_m[16:1]};
            shifts_m++;
         end
         exp_q.push_back(lfsr_m[0] ? 255 : 0);
         @(posedge clk);
         #1;
         want = exp_q.pop_front();
         vectors++;
         if (sound !== 10'(want)) begin
            errors++; $display("FAIL noise_p%0d n=%0d got %0d want %0d", per, n_cen, sound, want);
         end
         n_cen++;
      end
   endtask

   task automatic test_envelope();
      int want, t0, ep, steps;
      logic [3:0] shapes [7];
      shapes = '{4'hD, 4'h8, 4'hE, 4'h0, 4'h4, 4'hB, 4'hE};
      do_reset();
      wr(8, 8'h10); wr(7, 8'h3F); wr(12, 0);
      for (int i = 0; i < 7; i++) begin
         ep = (i == 6) ? 3 : 1;
         steps = (i == 6) ? 100 : 70;
         wr(11, ep);
         wr(13, int'(shapes[i]));
         t0 = n_cen / 16;
         cen = 1'b1;
         while ((n_cen / 16) - t0 < steps * ep) begin
            exp_q.push_back(vtab[env_val(shapes[i], ((n_cen / 16) - t0) / ep)]);
            @(posedge clk);
            #1;
            want = exp_q.pop_front();
            vectors++;
            if (sound !== 10'(want)) begin
               errors++;
               $display("FAIL env_shape%0h n=%0d got %0d want %0d", shapes[i], n_cen, sound, want);
            end
            n_cen++;
         end
      end
   endtask

   task automatic test_levels();
      int want;
      do_reset();
      wr(7, 8'h3F);
      for (int l = 0; l < 16; l++) begin
         wr(8, l); wr(9, 15 - l); wr(10, 8'h05);
         cen = 1'b1;
         for (int c = 0; c < 3; c++) begin
            exp_q.push_back(vtab[(l == 0) ? 0 : 2 * l + 1] + vtab[(l == 15) ? 0 : 2 * (15 - l) + 1] + vtab[11]);
            @(posedge clk);
            #1;
            want = exp_q.pop_front();
            vectors++;
            if (sound !== 10'(want)) begin
               errors++; $display("FAIL level_l%0d got %0d want %0d", l, sound, want);
            end
         end
      end
   endtask

   task automatic test_readback();
      logic [7:0] d;
      do_reset();
      cs_n = 1'b0; wr_n = 1'b0;
      for (int a = 0; a < 16; a++) begin
         d = (a == 1) ? 8'hFF : 8'($urandom_range(0, 255));
         addr = 4'(a); data_in = d;
         rd_q.push_back(d & bmask(a));
         @(posedge clk);
         #1;
      end
      cs_n = 1'b1; wr_n = 1'b1;
      for (int a = 0; a < 16; a++) begin
         addr = 4'(a);
         #1;
         d = rd_q.pop_front();
         vectors++;
         if (data_out !== d) begin
            errors++; $display("FAIL readback_reg%0d got %0h want %0h", a, data_out, d);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      test_reset();
      test_readback();
      test_levels();
      test_tone();
      test_three_tones();
      test_noise(1);
      test_noise(3);
      test_envelope();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
